snoop_bus_arbiter: RTL and testbench

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

---
 rtl/snoop_bus_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// -----------------------------------------------------------------------------
// snoop_bus_arbiter
// Round-robin arbiter for a snooping cache-coherence bus. It grants one
// processor port at a time, broadcasts the command to the snoopers, and then
// either finishes at once (invalidate), writes memory (write back, or a dirty
// snooper's intervention), or reads memory (clean miss). Completion is a single
// ack pulse to the winning port.
//
// Handshake: a port raises req[i] with req_cmd/req_addr/req_data stable. It
// keeps them until it sees ack[i] high for one cycle. The request is latched at
// grant, so dropping req early does not cancel the transaction.
//
// Ports:
//   clock, reset_n          clock (rising edge), async active-low reset
//   req/req_cmd/req_addr/
//   req_data                per-port request, command, address, write data
//   ack                     one-cycle completion pulse to the winner
//   rsp_data/rsp_shared     response data / shared flag, valid with ack
//   bus_valid/bus_cmd/
//   bus_addr/bus_src        snoop broadcast
//   snoop_shared/dirty/data per-snooper responses, sampled in SNOOP
//   mem_en/we/addr/wdata    memory request; mem_rdata returns one cycle later
//   busy                    high whenever the FSM is not idle
//   dbg_state               current FSM state, for checkers
// -----------------------------------------------------------------------------
module snoop_bus_arbiter #(
    parameter int N_PROC = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_PROC-1:0]        req,
    input  logic [2*N_PROC-1:0]      req_cmd,
    input  logic [ADDR_W*N_PROC-1:0] req_addr,
    input  logic [DATA_W*N_PROC-1:0] req_data,
    output logic [N_PROC-1:0]        ack,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_shared,
    output logic                     bus_valid,
    output logic [1:0]               bus_cmd,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [1:0]               bus_src,
    input  logic [N_PROC-1:0]        snoop_shared,
    input  logic [N_PROC-1:0]        snoop_dirty,
    input  logic [DATA_W*N_PROC-1:0] snoop_data,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy,
    output logic [2:0]               dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_BCAST, S_SNOOP, S_MEM_RD, S_MEM_WAIT, S_WB, S_MEM_WR, S_DONE
    } state_t;

    localparam logic [1:0] CMD_INVAL = 2'b10;
    localparam logic [1:0] CMD_WBACK = 2'b11;
    localparam logic [N_PROC-1:0] ONE = {{(N_PROC-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [1:0]          r_last;
    logic [1:0]          r_win;
    logic [1:0]          r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [N_PROC-1:0]   r_ack;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_shared;
    logic                r_bus_valid;
    logic [1:0]          r_bus_cmd;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [1:0]          r_bus_src;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_busy;

    logic                w_any;
    logic [1:0]          w_winner;
    int                  w_idx;
    int                  w_sel;
    logic [N_PROC-1:0]   w_own;
    logic [N_PROC-1:0]   w_m_shared;
    logic [N_PROC-1:0]   w_m_dirty;
    logic [DATA_W-1:0]   w_dirty_data;

    // Round-robin pick. Scanning from farthest to nearest lets the port closest
    // after r_last overwrite the others.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = N_PROC; k >= 1; k--) begin
            w_idx = (int'(r_last) + k) % N_PROC;
            if (req[w_idx]) begin
                w_any    = 1'b1;
                w_winner = 2'(w_idx);
            end
        end
    end

    assign w_sel      = int'(w_winner);
    assign w_own      = ONE << r_win;
    assign w_m_shared = snoop_shared & ~w_own;
    assign w_m_dirty  = snoop_dirty & ~w_own;

    // The lowest-index dirty snooper supplies the block. Scanning downward
    // leaves the lowest index as the final assignment.
    always_comb begin
        w_dirty_data = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (w_m_dirty[i]) w_dirty_data = snoop_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last       <= 2'(N_PROC - 1);
            r_win        <= '0;
            r_cmd        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_ack        <= '0;
            r_rsp_data   <= '0;
            r_rsp_shared <= 1'b0;
            r_bus_valid  <= 1'b0;
            r_bus_cmd    <= '0;
            r_bus_addr   <= '0;
            r_bus_src    <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            // Strobes are high only in the cycle after the transition that
            // sets them.
            r_ack       <= '0;
            r_bus_valid <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win       <= w_winner;
                        r_cmd       <= req_cmd[2*w_sel +: 2];
                        r_addr      <= req_addr[ADDR_W*w_sel +: ADDR_W];
                        r_data      <= req_data[DATA_W*w_sel +: DATA_W];
                        r_bus_valid <= 1'b1;
                        r_bus_cmd   <= req_cmd[2*w_sel +: 2];
                        r_bus_addr  <= req_addr[ADDR_W*w_sel +: ADDR_W];
                        r_bus_src   <= w_winner;
                        r_busy      <= 1'b1;
                        r_state     <= S_BCAST;
                    end
                end
                S_BCAST: r_state <= S_SNOOP;
                S_SNOOP: begin
                    r_rsp_shared <= |(w_m_shared | w_m_dirty);
                    if (r_cmd == CMD_INVAL) begin
                        r_ack   <= w_own;
                        r_state <= S_DONE;
                    end else if (r_cmd == CMD_WBACK) begin
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_data;
                        r_state     <= S_MEM_WR;
                    end else if (|w_m_dirty) begin
                        // The dirty owner's block goes to memory and to the
                        // requester in the same cycle.
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= w_dirty_data;
                        r_rsp_data  <= w_dirty_data;
                        r_state     <= S_WB;
                    end else begin
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_state    <= S_MEM_RD;
                    end
                end
                S_MEM_RD: r_state <= S_MEM_WAIT;
                S_MEM_WAIT: begin
                    r_rsp_data <= mem_rdata;
                    r_ack      <= w_own;
                    r_state    <= S_DONE;
                end
                S_WB, S_MEM_WR: begin
                    r_ack   <= w_own;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_last      <= r_win;
                    r_busy      <= 1'b0;
                    r_bus_cmd   <= '0;
                    r_bus_addr  <= '0;
                    r_bus_src   <= '0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack        = r_ack;
    assign rsp_data   = r_rsp_data;
    assign rsp_shared = r_rsp_shared;
    assign bus_valid  = r_bus_valid;
    assign bus_cmd    = r_bus_cmd;
    assign bus_addr   = r_bus_addr;
    assign bus_src    = r_bus_src;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_snoop_bus_arbiter
// Directed and random transactions against snoop_bus_arbiter. The expected
// outcome of each transaction is derived from the arbitration and coherence
// rules: round-robin winner, masked snoop flags, ack latency per path, and
// memory contents.
// -----------------------------------------------------------------------------
module tb_snoop_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req = '0;
    logic [5:0]  req_cmd = '0;
    logic [14:0] req_addr = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  ack;
    logic [7:0]  rsp_data;
    logic        rsp_shared;
    logic        bus_valid;
    logic [1:0]  bus_cmd;
    logic [4:0]  bus_addr;
    logic [1:0]  bus_src;
    logic [2:0]  snoop_shared = '0;
    logic [2:0]  snoop_dirty = '0;
    logic [23:0] snoop_data = '0;
    logic        mem_en;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        busy;
    logic [2:0]  dbg_state;

    snoop_bus_arbiter dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data), .ack(ack),
        .rsp_data(rsp_data), .rsp_shared(rsp_shared), .bus_valid(bus_valid),
        .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_src(bus_src),
        .snoop_shared(snoop_shared), .snoop_dirty(snoop_dirty),
        .snoop_data(snoop_data), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc++;

    // ---------------- environment: memory and bus monitor ----------------
    logic [7:0] tb_mem [32];
    bit         mem_init = 0;
    int         wr_cnt = 0, rd_cnt = 0, bv_cnt = 0, ack_cnt = 0;
    logic [1:0] cap_cmd;
    logic [4:0] cap_addr;
    logic [1:0] cap_src;

    function automatic logic [7:0] init_pat(int a);
        return 8'((a * 37 + 11) & 8'hFF);
    endfunction

    always @(negedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) tb_mem[i] = init_pat(i);
            mem_init = 1;
        end
        if (mem_en && mem_we) begin
            tb_mem[mem_addr] = mem_wdata;
            wr_cnt++;
        end
        if (mem_en && !mem_we) rd_cnt++;
        if (bus_valid) begin
            bv_cnt++;
            cap_cmd  = bus_cmd;
            cap_addr = bus_addr;
            cap_src  = bus_src;
        end
        if (|ack) ack_cnt++;
    end

    // Read data appears the cycle after a read strobe; junk otherwise.
    always @(posedge clock) begin
        if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr];
        else                   mem_rdata <= 8'($urandom);
    end

    // ---------------- reference model state ----------------
    logic [7:0] exp_mem [32];
    logic [7:0] m_rsp = '0;
    logic       m_sh  = 1'b0;

    function automatic int rr_pick(logic [2:0] r, int last);
        for (int k = 1; k <= 3; k++) begin
            if (r[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one single-port transaction ----------------
    task automatic run_txn(input int p, input logic [1:0] cmd, input logic [4:0] a,
                           input logic [7:0] d, input logic [2:0] sh,
                           input logic [2:0] dy, input logic [23:0] sd,
                           input bit drop);
        logic [2:0] ms, md;
        int exp_lat, exp_wr, exp_rd, lat, wr0, rd0, bv0, di;
        bit got;
        ms = sh & ~(3'b001 << p);
        md = dy & ~(3'b001 << p);
        m_sh = |(ms | md);
        exp_wr = 0;
        exp_rd = 0;
        if (cmd == 2'b10) begin
            exp_lat = 3;
        end else if (cmd == 2'b11) begin
            exp_lat = 4; exp_wr = 1; exp_mem[a] = d;
        end else if (md != 0) begin
            di = 0;
            while (!md[di]) di++;
            exp_lat = 4; exp_wr = 1;
            exp_mem[a] = sd[8*di +: 8];
            m_rsp = sd[8*di +: 8];
        end else begin
            exp_lat = 5; exp_rd = 1; m_rsp = exp_mem[a];
        end
        req_cmd  = 6'($urandom);
        req_addr = 15'($urandom);
        req_data = 24'($urandom);
        req_cmd[2*p +: 2]  = cmd;
        req_addr[5*p +: 5] = a;
        req_data[8*p +: 8] = d;
        snoop_shared = sh;
        snoop_dirty  = dy;
        snoop_data   = sd;
        wr0 = wr_cnt; rd0 = rd_cnt; bv0 = bv_cnt;
        req[p] = 1'b1;
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (drop && lat == 1) req[p] = 1'b0;
            if (|ack) got = 1;
        end
        chk("ack_latency", lat, exp_lat);
        chk("ack_port", ack, 3'b001 << p);
        chk("rsp_data", rsp_data, m_rsp);
        chk("rsp_shared", rsp_shared, m_sh);
        chk("bus_hold_addr", bus_addr, a);
        req[p] = 1'b0;
        chk("bus_strobes", bv_cnt - bv0, 1);
        chk("bus_cmd", cap_cmd, cmd);
        chk("bus_addr", cap_addr, a);
        chk("bus_src", cap_src, p);
        chk("mem_writes", wr_cnt - wr0, exp_wr);
        chk("mem_reads", rd_cnt - rd0, exp_rd);
        if (exp_wr != 0) chk("mem_content", tb_mem[a], exp_mem[a]);
        @(negedge clock);
        chk("ack_one_cycle", ack, 0);
        chk("idle_busy", busy, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [2:0] req_after [5];
    int         exp_order [5];

    initial begin
        int last, w, prev_cyc, lat, a0;
        bit got;
        for (int i = 0; i < 32; i++) exp_mem[i] = init_pat(i);

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rsp_data", rsp_data, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Invalidate from port 2, every snooper shared: own bit masked.
        run_txn(2, 2'b10, 5'h07, 8'h00, 3'b111, 3'b000, 24'h0, 0);
        // Write back 3C to address 0A from port 0.
        run_txn(0, 2'b11, 5'h0A, 8'h3C, 3'b000, 3'b000, 24'h0, 0);
        // Clean read miss from port 1 at 0A.
        run_txn(1, 2'b00, 5'h0A, 8'h00, 3'b000, 3'b000, 24'h0, 0);
        chk("read_0A_value", rsp_data, 8'h3C);
        // Read miss from port 0 at 11 with snooper 2 dirty, data A5.
        run_txn(0, 2'b00, 5'h11, 8'h00, 3'b000, 3'b100, 24'hA5_0000, 0);
        chk("wb_mem_11", tb_mem[5'h11], 8'hA5);
        // Own dirty bit is ignored: plain memory read.
        run_txn(1, 2'b01, 5'h03, 8'h00, 3'b010, 3'b010, 24'h00_FF00, 0);

        // Simultaneous requests; port 0 holds, port 2 re-requests.
        req_after[0] = 3'b111; req_after[1] = 3'b101; req_after[2] = 3'b101;
        req_after[3] = 3'b100; req_after[4] = 3'b000;
        req_cmd = 6'b10_10_10;
        snoop_shared = '0; snoop_dirty = '0;
        last = 1;
        req = 3'b111;
        prev_cyc = cyc;
        for (int s = 0; s < 5; s++) begin
            exp_order[s] = rr_pick(req, last);
            lat = 0; got = 0;
            while (!got && lat < 20) begin
                @(negedge clock);
                lat++;
                if (|ack) got = 1;
            end
            w = (ack == 3'b001) ? 0 : (ack == 3'b010) ? 1 : (ack == 3'b100) ? 2 : -1;
            chk("rr_winner", w, exp_order[s]);
            chk("rr_spacing", cyc - prev_cyc, (s == 0) ? 3 : 4);
            prev_cyc = cyc;
            last = w;
            req = req_after[s];
        end
        @(negedge clock);
        chk("rr_idle", busy, 0);

        // Reset during MEM_WAIT of a port-1 read.
        a0 = 5'h15;
        req_cmd = '0;
        req_addr = '0;
        req_addr[5 +: 5] = 5'(a0);
        req = 3'b010;
        repeat (4) @(negedge clock);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_mem_en", mem_en, 0);
        w = ack_cnt;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_bus_addr", bus_addr, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        chk("mid_rst_ack", ack, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        chk("no_ack_aborted", ack_cnt - w, 0);
        m_rsp = '0;
        m_sh  = 1'b0;
        run_txn(1, 2'b00, 5'(a0), 8'h00, 3'b000, 3'b000, 24'h0, 0);

        // Random single-port transactions, some dropping req early.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            run_txn($urandom_range(0, 2), 2'($urandom_range(0, 3)),
                    5'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7)) : 3'b000,
                    24'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
